tdm_demux_2ch: RTL and testbench
================================

TDM_DEMUX_2CH -- requirements
Module: tdm_demux_2ch

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the data width of DIN, OUT_A and OUT_B.
REQ-002 CLK  input  1  sole clock, all state on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 CLR  input  1  synchronous clear of the error flag, counter and sequence state.
REQ-005 DIN  input  WIDTH  time-multiplexed sample from the upstream 2:1 mux.
REQ-006 DIN_VALID  input  1  DIN/SEL qualify this cycle.
REQ-007 SEL  input  1  channel tag: 0 = channel A sample, 1 = channel B sample.
REQ-008 OUT_A  output  WIDTH  last complete-pair channel A sample.
REQ-009 OUT_B  output  WIDTH  last complete-pair channel B sample.
REQ-010 PAIR_VALID  output  1  one-cycle pulse, new coherent pair on OUT_A/OUT_B.
REQ-011 SEQ_ERR  output  1  sticky out-of-order tag flag.
REQ-012 PAIR_CNT  output  8  completed-pair count, modulo 256.

Function
REQ-013 FSM SHALL have exactly two states: WAIT_A (reset state) and WAIT_B.
REQ-014 WAIT_A, DIN_VALID=1, SEL=0: DIN -> shadow A register; next state WAIT_B.
REQ-015 WAIT_A, DIN_VALID=1, SEL=1: sample discarded; SEQ_ERR set; stay WAIT_A.
REQ-016 WAIT_B, DIN_VALID=1, SEL=1: OUT_A <= shadow A, OUT_B <= DIN, PAIR_VALID=1 for the following cycle, PAIR_CNT incremented, next state WAIT_A.
REQ-017 WAIT_B, DIN_VALID=1, SEL=0: SEQ_ERR set; shadow A overwritten with DIN (resync on newest A); stay WAIT_B.
REQ-018 DIN_VALID=0: no state, shadow, output or flag change; PAIR_VALID=0.
REQ-019 OUT_A/OUT_B SHALL change only on pair completion, never on a single accepted sample.
REQ-020 Latency: the B sample accepted at edge N SHALL be visible on OUT_B, with PAIR_VALID high, from edge N to edge N+1.
REQ-021 PAIR_CNT SHALL wrap 255 -> 0 with no flag.
REQ-022 SEQ_ERR SHALL remain set until CLR or RST; a further error while it is set has no extra effect.
REQ-023 CLR=1: SEQ_ERR <= 0, PAIR_CNT <= 0, state <= WAIT_A, PAIR_VALID <= 0; OUT_A/OUT_B hold.
REQ-024 CLR and DIN_VALID in the same cycle: CLR wins, sample discarded, no error raised.
REQ-025 Back-to-back DIN_VALID every cycle SHALL be accepted with no stall; a pair every 2 cycles.

Reset
REQ-026 RST=1 SHALL asynchronously force state WAIT_A, OUT_A=0, OUT_B=0, shadow A=0, PAIR_VALID=0, SEQ_ERR=0, PAIR_CNT=0.
REQ-027 RST asserted mid-pair (in WAIT_B) SHALL discard the pending A sample; the first post-reset pair SHALL start with an A sample.
REQ-028 Release of RST SHALL be taken synchronously; the first sample is accepted at the first rising edge after deassertion.

Structure
REQ-029 State encodings (WAIT_A=0, WAIT_B=1) and WIDTH default SHALL live in shared package tdm_demux_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; the pair counter is inline.

Verification
REQ-031 Reset, then A=0x11 (SEL=0) then B=0x22 (SEL=1) on consecutive cycles -> OUT_A=0x11, OUT_B=0x22, PAIR_VALID one cycle, PAIR_CNT=1, SEQ_ERR=0.
REQ-032 From WAIT_A, SEL=1 DIN=0x55 -> SEQ_ERR=1, outputs unchanged; then A=0x01, B=0x02 -> pair 0x01/0x02 completes, SEQ_ERR still 1.
REQ-033 A=0x10, A=0x20, B=0x30 -> SEQ_ERR=1, OUT_A=0x20, OUT_B=0x30 (resync on newest A).
REQ-034 256 back-to-back pairs -> PAIR_CNT returns to 0, 256 PAIR_VALID pulses, no gaps.
REQ-035 A=0x0F accepted, RST pulsed, then B=0xF0 -> SEQ_ERR=1, no pair, OUT_A=OUT_B=0.
REQ-036 CLR with DIN_VALID=1, SEL=1 in the same cycle while SEQ_ERR=1 -> SEQ_ERR=0, PAIR_CNT=0, state WAIT_A, no error, sample dropped.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the two-channel TDM demultiplexer.
// The FSM encoding is fixed here so that checkers and the RTL agree on it.
package tdm_demux_pkg;

   localparam int TDM_WIDTH_DEFAULT = 8;

   typedef enum logic {
      WAIT_A = 1'b0,
      WAIT_B = 1'b1
   } tdm_state_e;

endpackage : tdm_demux_pkg

// File: rtl/tdm_demux_2ch.sv
// Splits an A/B time-multiplexed sample stream into coherent channel pairs.
// Out-of-order tags raise a sticky flag, and the pair is rebuilt from the next A sample.
module tdm_demux_2ch
   import tdm_demux_pkg::*;
#(
   parameter int WIDTH = TDM_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sel,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             pair_valid,
   output logic             seq_err,
   output logic [7:0]       pair_cnt,
   output tdm_state_e       dbg_state
);

   tdm_state_e       state_q, state_d;
   logic [WIDTH-1:0] shadow_a_q, shadow_a_d;
   logic [WIDTH-1:0] out_a_q, out_a_d;
   logic [WIDTH-1:0] out_b_q, out_b_d;
   logic             pair_valid_q, pair_valid_d;
   logic             seq_err_q, seq_err_d;
   logic [7:0]       pair_cnt_q, pair_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= WAIT_A;
         shadow_a_q   <= '0;
         out_a_q      <= '0;
         out_b_q      <= '0;
         pair_valid_q <= 1'b0;
         seq_err_q    <= 1'b0;
         pair_cnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         shadow_a_q   <= shadow_a_d;
         out_a_q      <= out_a_d;
         out_b_q      <= out_b_d;
         pair_valid_q <= pair_valid_d;
         seq_err_q    <= seq_err_d;
         pair_cnt_q   <= pair_cnt_d;
      end
   end

   // Clear takes priority over a coincident sample, so that sample is dropped silently.
   always_comb begin
      state_d      = state_q;
      shadow_a_d   = shadow_a_q;
      out_a_d      = out_a_q;
      out_b_d      = out_b_q;
      pair_valid_d = 1'b0;
      seq_err_d    = seq_err_q;
      pair_cnt_d   = pair_cnt_q;
      if (clr) begin
         state_d    = WAIT_A;
         seq_err_d  = 1'b0;
         pair_cnt_d = 8'd0;
      end else if (din_valid) begin
         unique case (state_q)
            WAIT_A: begin
               if (!sel) begin
                  shadow_a_d = din;
                  state_d    = WAIT_B;
               end else begin
                  seq_err_d = 1'b1;
               end
            end
            WAIT_B: begin
               if (sel) begin
                  out_a_d      = shadow_a_q;
                  out_b_d      = din;
                  pair_valid_d = 1'b1;
                  pair_cnt_d   = pair_cnt_q + 8'd1;
                  state_d      = WAIT_A;
               end else begin
                  // A repeated A sample replaces the stale one.
                  seq_err_d  = 1'b1;
                  shadow_a_d = din;
               end
            end
            default: state_d = WAIT_A;
         endcase
      end
   end

   assign out_a      = out_a_q;
   assign out_b      = out_b_q;
   assign pair_valid = pair_valid_q;
   assign seq_err    = seq_err_q;
   assign pair_cnt   = pair_cnt_q;
   assign dbg_state  = state_q;

endmodule : tdm_demux_2ch

// File: tb/tb_tdm_demux_2ch.sv
// Directed bench for tdm_demux_2ch: a queue-based pairing model checked every cycle,
// plus literal expectations for the named scenarios.
module tb_tdm_demux_2ch;
   import tdm_demux_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] out_a, out_b, pair_cnt;
   logic       pair_valid, seq_err;
   tdm_state_e dbg_state;

   int total = 0;
   int bad = 0;
   bit cmp_en = 1'b0;
   int pv_seen = 0;

   tdm_demux_2ch #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid), .sel(sel),
      .out_a(out_a), .out_b(out_b), .pair_valid(pair_valid), .seq_err(seq_err),
      .pair_cnt(pair_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Model: a pending-A queue holds at most the newest unmatched A sample.
   logic [7:0] m_a = 8'h00, m_b = 8'h00, m_cnt = 8'h00;
   bit         m_pv = 1'b0, m_err = 1'b0;
   logic [7:0] pend_q[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_a = 8'h00; m_b = 8'h00; m_cnt = 8'h00; m_pv = 1'b0; m_err = 1'b0;
         pend_q.delete();
      end else begin
         m_pv = 1'b0;
         if (clr) begin
            m_err = 1'b0; m_cnt = 8'h00;
            pend_q.delete();
         end else if (din_valid) begin
            if (!sel) begin
               if (pend_q.size() != 0) begin
                  m_err = 1'b1;
                  pend_q.delete();
               end
               pend_q.push_back(din);
            end else if (pend_q.size() == 0) begin
               m_err = 1'b1;
            end else begin
               m_a = pend_q.pop_front();
               m_b = din;
               m_pv = 1'b1;
               m_cnt = m_cnt + 8'd1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         check("cyc_out_a", 32'(out_a), 32'(m_a));
         check("cyc_out_b", 32'(out_b), 32'(m_b));
         check("cyc_pair_valid", 32'(pair_valid), 32'(m_pv));
         check("cyc_seq_err", 32'(seq_err), 32'(m_err));
         check("cyc_pair_cnt", 32'(pair_cnt), 32'(m_cnt));
         check("cyc_state", 32'(dbg_state), (pend_q.size() != 0) ? 32'd1 : 32'd0);
         if (pair_valid) pv_seen++;
      end
   end

   task automatic step(input logic v, input logic s, input logic [7:0] d, input logic c);
      @(negedge clk);
      din_valid = v; sel = s; din = d; clr = c;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      #1;
      check("rst_out_a", 32'(out_a), 32'h0);
      check("rst_out_b", 32'(out_b), 32'h0);
      check("rst_pv", 32'(pair_valid), 32'h0);
      check("rst_err", 32'(seq_err), 32'h0);
      check("rst_cnt", 32'(pair_cnt), 32'h0);

      // Basic pair
      step(1'b1, 1'b0, 8'h11, 1'b0);
      step(1'b1, 1'b1, 8'h22, 1'b0);
      idle(); #1;
      check("pair1_a", 32'(out_a), 32'h11);
      check("pair1_b", 32'(out_b), 32'h22);
      check("pair1_pv", 32'(pair_valid), 32'h1);
      check("pair1_cnt", 32'(pair_cnt), 32'h1);
      check("pair1_err", 32'(seq_err), 32'h0);
      idle(); #1;
      check("pair1_pv_drop", 32'(pair_valid), 32'h0);

      // Stray B in WAIT_A
      step(1'b1, 1'b1, 8'h55, 1'b0);
      idle(); #1;
      check("strayb_err", 32'(seq_err), 32'h1);
      check("strayb_a_hold", 32'(out_a), 32'h11);
      check("strayb_b_hold", 32'(out_b), 32'h22);
      step(1'b1, 1'b0, 8'h01, 1'b0);
      idle(); #1;
      check("single_a_no_out", 32'(out_a), 32'h11);
      step(1'b1, 1'b1, 8'h02, 1'b0);
      idle(); #1;
      check("pair2_a", 32'(out_a), 32'h01);
      check("pair2_b", 32'(out_b), 32'h02);
      check("pair2_err_sticky", 32'(seq_err), 32'h1);
      check("pair2_cnt", 32'(pair_cnt), 32'h2);

      // Resync on newest A
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h10, 1'b0);
      step(1'b1, 1'b0, 8'h20, 1'b0);
      step(1'b1, 1'b1, 8'h30, 1'b0);
      idle(); #1;
      check("resync_err", 32'(seq_err), 32'h1);
      check("resync_a", 32'(out_a), 32'h20);
      check("resync_b", 32'(out_b), 32'h30);
      check("resync_cnt", 32'(pair_cnt), 32'h1);

      // 256 back-to-back pairs wrap the counter
      step(1'b0, 1'b0, 8'h00, 1'b1);
      idle();
      pv_seen = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
         step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      end
      idle(); #1;
      check("wrap_cnt", 32'(pair_cnt), 32'h0);
      check("wrap_err", 32'(seq_err), 32'h0);
      idle();
      check("wrap_pulses", 32'(pv_seen), 32'd256);

      // Reset mid-pair drops the pending A
      step(1'b1, 1'b0, 8'h0F, 1'b0);
      idle();
      rst = 1'b1;
      #2 rst = 1'b0;
      step(1'b1, 1'b1, 8'hF0, 1'b0);
      idle(); #1;
      check("rstmid_err", 32'(seq_err), 32'h1);
      check("rstmid_pv", 32'(pair_valid), 32'h0);
      check("rstmid_cnt", 32'(pair_cnt), 32'h0);
      check("rstmid_a", 32'(out_a), 32'h0);
      check("rstmid_b", 32'(out_b), 32'h0);

      // Clear beats a coincident sample
      step(1'b1, 1'b0, 8'hAA, 1'b0);
      step(1'b1, 1'b1, 8'hBB, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b1);
      idle(); #1;
      check("clr_err", 32'(seq_err), 32'h0);
      check("clr_cnt", 32'(pair_cnt), 32'h0);
      check("clr_state", 32'(dbg_state), 32'(WAIT_A));
      check("clr_pv", 32'(pair_valid), 32'h0);
      check("clr_out_hold", 32'(out_b), 32'hBB);
      step(1'b1, 1'b0, 8'h3C, 1'b1);
      step(1'b1, 1'b0, 8'h5A, 1'b0);
      step(1'b1, 1'b1, 8'hA5, 1'b0);
      idle(); #1;
      check("post_clr_a", 32'(out_a), 32'h5A);
      check("post_clr_b", 32'(out_b), 32'hA5);
      check("post_clr_cnt", 32'(pair_cnt), 32'h1);
      check("post_clr_err", 32'(seq_err), 32'h0);
      idle();

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tdm_demux_2ch
